addsub_arbiter: RTL and testbench

//  Shares one WIDTH-bit adder/subtractor between two requesters (port 0, port 1).

---
 rtl/addsub_pkg.sv | 18 +
 rtl/addsub_core.sv | 29 ++
 rtl/addsub_arbiter.sv | 141 ++++++++++++++
 tb/tb_addsub_arbiter.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared types and constants for the add/subtract arbiter slice.
package addsub_pkg;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Round-robin pointer moves to the port that did not just win.
    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/addsub_core.sv
// Combinational ripple-carry adder/subtractor: sel=1 computes a + ~b + 1.
module addsub_core #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sel,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] b_x_s;
    logic [WIDTH:0]   carry_s;

    assign b_x_s = b ^ {WIDTH{sel}};

    // Ripple chain; carry-in equals sel so subtraction becomes two's complement.
    always_comb begin
        carry_s    = {(WIDTH+1){1'b0}};
        sum        = {WIDTH{1'b0}};
        carry_s[0] = sel;
        for (int i = 0; i < WIDTH; i++) begin
            sum[i]       = a[i] ^ b_x_s[i] ^ carry_s[i];
            carry_s[i+1] = (a[i] & b_x_s[i]) | (a[i] & carry_s[i]) | (b_x_s[i] & carry_s[i]);
        end
        cout = carry_s[WIDTH];
    end

endmodule

// File: rtl/addsub_arbiter.sv
// Round-robin arbiter sharing one addsub_core between two requesters.
module addsub_arbiter
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0,
    input  logic             sel0,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] b0,
    output logic             gnt0,
    output logic             done0,
    input  logic             req1,
    input  logic             sel1,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] b1,
    output logic             gnt1,
    output logic             done1,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             busy
);

    state_e           state_q, state_d;
    logic             ptr_q, ptr_d;
    logic             owner_q, owner_d;
    logic             op_sel_q, op_sel_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             cout_q, cout_d;
    logic             done0_q, done0_d;
    logic             done1_q, done1_d;
    logic             busy_q, busy_d;
    logic             gnt0_s, gnt1_s;
    logic [WIDTH-1:0] core_sum_s;
    logic             core_cout_s;

    addsub_core #(.WIDTH(WIDTH)) u_core (
        .a    (op_a_q),
        .b    (op_b_q),
        .sel  (op_sel_q),
        .sum  (core_sum_s),
        .cout (core_cout_s)
    );

    // Next-state, arbitration and operand/result capture.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        op_sel_d = op_sel_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        result_d = result_q;
        cout_d   = cout_q;
        done0_d  = 1'b0;
        done1_d  = 1'b0;
        gnt0_s   = 1'b0;
        gnt1_s   = 1'b0;
        case (state_q)
            IDLE: begin
                // Port 0 wins when alone or when the pointer favours it.
                if (req0 && (!req1 || (ptr_q == 1'b0))) begin
                    gnt0_s   = 1'b1;
                    owner_d  = 1'b0;
                    op_sel_d = sel0;
                    op_a_d   = a0;
                    op_b_d   = b0;
                    ptr_d    = other_port(1'b0);
                    state_d  = EXEC;
                end else if (req1) begin
                    gnt1_s   = 1'b1;
                    owner_d  = 1'b1;
                    op_sel_d = sel1;
                    op_a_d   = a1;
                    op_b_d   = b1;
                    ptr_d    = other_port(1'b1);
                    state_d  = EXEC;
                end else begin
                    state_d  = IDLE;
                end
            end
            EXEC: begin
                result_d = core_sum_s;
                cout_d   = core_cout_s;
                done0_d  = (owner_q == 1'b0);
                done1_d  = (owner_q == 1'b1);
                state_d  = RESP;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State, pointer, operand latch and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            ptr_q    <= 1'b0;
            owner_q  <= 1'b0;
            op_sel_q <= 1'b0;
            op_a_q   <= {WIDTH{1'b0}};
            op_b_q   <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            cout_q   <= 1'b0;
            done0_q  <= 1'b0;
            done1_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            op_sel_q <= op_sel_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            done0_q  <= done0_d;
            done1_q  <= done1_d;
            busy_q   <= busy_d;
        end
    end

    // Grant is the sampling strobe in IDLE, so it is held low while reset is applied.
    assign gnt0   = gnt0_s & ~rst;
    assign gnt1   = gnt1_s & ~rst;
    assign done0  = done0_q;
    assign done1  = done1_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign busy   = busy_q;

endmodule

// File: tb/tb_addsub_arbiter.sv
// Directed self-checking bench for addsub_arbiter (WIDTH=4).
module tb_addsub_arbiter;
    import addsub_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, sel0 = 1'b0, req1 = 1'b0, sel1 = 1'b0;
    logic [3:0] a0 = 4'd0, b0 = 4'd0, a1 = 4'd0, b1 = 4'd0;
    logic       gnt0, gnt1, done0, done1, cout, busy;
    logic [3:0] result;
    int         checks = 0;
    int         errors = 0;

    addsub_arbiter #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .sel0(sel0), .a0(a0), .b0(b0), .gnt0(gnt0), .done0(done0),
        .req1(req1), .sel1(sel1), .a1(a1), .b1(b1), .gnt1(gnt1), .done1(done1),
        .result(result), .cout(cout), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One isolated request on one port, checked through grant, EXEC, RESP and back to IDLE.
    task automatic do_single(input logic port, input logic sel, input logic [3:0] a,
                             input logic [3:0] b, input logic [3:0] exp_r,
                             input logic exp_c, input string tag);
        if (port == 1'b0) begin
            req0 = 1'b1; sel0 = sel; a0 = a; b0 = b;
        end else begin
            req1 = 1'b1; sel1 = sel; a1 = a; b1 = b;
        end
        #1;
        chk({tag, "_gnt0"}, {31'd0, gnt0}, {31'd0, ~port});
        chk({tag, "_gnt1"}, {31'd0, gnt1}, {31'd0, port});
        chk({tag, "_busy_idle"}, {31'd0, busy}, 32'd0);
        tick();
        req0 = 1'b0; req1 = 1'b0;
        a0 = 4'd0; b0 = 4'd0; a1 = 4'd0; b1 = 4'd0;
        #1;
        chk({tag, "_gnt_exec"}, {30'd0, gnt1, gnt0}, 32'd0);
        chk({tag, "_busy_exec"}, {31'd0, busy}, 32'd1);
        chk({tag, "_done_exec"}, {30'd0, done1, done0}, 32'd0);
        tick();
        chk({tag, "_done0"}, {31'd0, done0}, {31'd0, ~port});
        chk({tag, "_done1"}, {31'd0, done1}, {31'd0, port});
        chk({tag, "_result"}, {28'd0, result}, {28'd0, exp_r});
        chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_c});
        chk({tag, "_busy_resp"}, {31'd0, busy}, 32'd1);
        tick();
        chk({tag, "_done_after"}, {30'd0, done1, done0}, 32'd0);
        chk({tag, "_busy_after"}, {31'd0, busy}, 32'd0);
        chk({tag, "_result_held"}, {28'd0, result}, {28'd0, exp_r});
    endtask

    initial begin
        // Reset state
        tick();
        tick();
        chk("rst_gnt", {30'd0, gnt1, gnt0}, 32'd0);
        chk("rst_done", {30'd0, done1, done0}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_result", {28'd0, result}, 32'd0);
        chk("rst_cout", {31'd0, cout}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        tick();
        chk("idle_busy", {31'd0, busy}, 32'd0);
        chk("idle_gnt", {30'd0, gnt1, gnt0}, 32'd0);

        // Single operations
        do_single(1'b0, OP_ADD, 4'd5, 4'd1, 4'd6, 1'b0, "add5p1");
        do_single(1'b1, OP_SUB, 4'd5, 4'd1, 4'd4, 1'b1, "sub5m1");
        do_single(1'b1, OP_SUB, 4'd1, 4'd5, 4'd12, 1'b0, "sub1m5");
        do_single(1'b0, OP_ADD, 4'd9, 4'd8, 4'd1, 1'b1, "add_wrap");

        // Both ports requesting continuously from reset: grants alternate 0,1,0,1
        rst = 1'b1;
        tick();
        rst = 1'b0;
        req0 = 1'b1; sel0 = OP_ADD; a0 = 4'd2; b0 = 4'd2;
        req1 = 1'b1; sel1 = OP_SUB; a1 = 4'd2; b1 = 4'd2;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rr_gnt0", {31'd0, gnt0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_gnt1", {31'd0, gnt1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            tick();
            tick();
            chk("rr_done0", {31'd0, done0}, (k % 2 == 0) ? 32'd1 : 32'd0);
            chk("rr_done1", {31'd0, done1}, (k % 2 == 1) ? 32'd1 : 32'd0);
            chk("rr_result", {28'd0, result}, (k % 2 == 0) ? 32'd4 : 32'd0);
            chk("rr_cout", {31'd0, cout}, (k % 2 == 0) ? 32'd0 : 32'd1);
            tick();
        end
        req0 = 1'b0; req1 = 1'b0;
        tick();

        // Reset during EXEC abandons the operation
        req0 = 1'b1; sel0 = OP_ADD; a0 = 4'd15; b0 = 4'd1;
        #1;
        chk("rstmid_gnt0", {31'd0, gnt0}, 32'd1);
        tick();
        req0 = 1'b0;
        rst = 1'b1;
        #1;
        chk("rstmid_busy", {31'd0, busy}, 32'd0);
        chk("rstmid_cout", {31'd0, cout}, 32'd0);
        chk("rstmid_result", {28'd0, result}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("rstmid_done0", {30'd0, done1, done0}, 32'd0);
        tick();
        chk("rstmid_done0_late", {30'd0, done1, done0}, 32'd0);
        do_single(1'b0, OP_ADD, 4'd15, 4'd1, 4'd0, 1'b1, "add15p1");

        // req0 withdrawn while port 1 is being served
        req1 = 1'b1; sel1 = OP_SUB; a1 = 4'd7; b1 = 4'd2;
        #1;
        chk("cancel_gnt1", {31'd0, gnt1}, 32'd1);
        tick();
        req1 = 1'b0;
        req0 = 1'b1; sel0 = OP_ADD; a0 = 4'd9; b0 = 4'd9;
        tick();
        chk("cancel_done1", {31'd0, done1}, 32'd1);
        chk("cancel_result", {28'd0, result}, 32'd5);
        chk("cancel_cout", {31'd0, cout}, 32'd1);
        req0 = 1'b0;
        #1;
        tick();
        chk("cancel_gnt_idle", {30'd0, gnt1, gnt0}, 32'd0);
        chk("cancel_busy_idle", {31'd0, busy}, 32'd0);
        tick();
        chk("cancel_done0", {30'd0, done1, done0}, 32'd0);
        chk("cancel_result_held", {28'd0, result}, 32'd5);
        chk("cancel_cout_held", {31'd0, cout}, 32'd1);
        tick();
        chk("cancel_busy_end", {31'd0, busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
